// File: rtl/cpu_run_monitor_pkg.sv
// Shared types for the MIPS core run monitor.
// State encoding and default end-of-program PC.
package cpu_run_monitor_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] DEF_HALT_PC = 32'h0000_01FC;

endpackage

// File: rtl/mon_sig_fold.sv
// Combinational rotate/XOR chain folding valid result
// channels into the signature, channel 0 first.
module mon_sig_fold #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 3
) (
  input  logic [DATA_W-1:0]        sig_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  output logic [DATA_W-1:0]        sig_o
);

  logic [DATA_W-1:0] acc;

  always_comb begin
    acc = sig_i;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_valid_i[k]) begin
        acc = {acc[DATA_W-2:0], acc[DATA_W-1]}
            ^ ch_data_i[k*DATA_W +: DATA_W];
      end
    end
    sig_o = acc;
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller/checker for the pipelined MIPS core:
// reset, run to halt PC or timeout, drain, compare signature.
module cpu_run_monitor
  import cpu_run_monitor_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int NUM_CH       = 3,
  parameter int RST_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 5,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 16,
  parameter logic [DATA_W-1:0] HALT_PC = DATA_W'(DEF_HALT_PC)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [DATA_W-1:0]        PC,
  input  logic [NUM_CH*DATA_W-1:0] ChData,
  input  logic [NUM_CH-1:0]        ChValid,
  input  logic [DATA_W-1:0]        ExpSig,
  output logic                     CoreReset,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Pass,
  output logic                     TimedOut,
  output logic [CNT_W-1:0]         CycleCount,
  output logic [DATA_W-1:0]        Signature
);

  localparam int MAX_A = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int MAX_P = (MAX_A > DRAIN_CYCLES) ? MAX_A : DRAIN_CYCLES;
  localparam int PH_W  = $clog2(MAX_P + 1);

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] sig_q, sig_d, sig_fold;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              crst_q, crst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              tmo_q, tmo_d;

  mon_sig_fold #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH)
  ) u_fold (
    .sig_i      (sig_q),
    .ch_data_i  (ChData),
    .ch_valid_i (ChValid),
    .sig_o      (sig_fold)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    exp_d   = exp_q;
    crst_d  = crst_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_RESET;
          ph_d    = '0;
          cnt_d   = '0;
          sig_d   = '0;
          exp_d   = ExpSig;
          crst_d  = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      S_RESET: begin
        if (ph_q == PH_W'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
          ph_d    = '0;
          crst_d  = 1'b0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        sig_d = sig_fold;
        // Halt takes priority over a timeout on the same cycle
        if (PC == HALT_PC) begin
          state_d = S_DRAIN;
          ph_d    = '0;
        end else if (ph_q == PH_W'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          crst_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_inc;
        sig_d = sig_fold;
        if (ph_q == PH_W'(DRAIN_CYCLES - 1)) begin
          state_d = S_DONE;
          crst_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (sig_fold == exp_q);
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        crst_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
      exp_q   <= '0;
      crst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      exp_q   <= exp_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
    end
  end

  assign CoreReset  = crst_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Pass       = pass_q;
  assign TimedOut   = tmo_q;
  assign CycleCount = cnt_q;
  assign Signature  = sig_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomised bench for cpu_run_monitor against a
// run-level reference model of signature, count and verdict.
module tb_cpu_run_monitor;

  localparam int DW    = 32;
  localparam int NCH   = 3;
  localparam int RSTC  = 4;
  localparam int DRNC  = 5;
  localparam int TMO   = 28;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;
  localparam logic [31:0] HALT = 32'h0000_01FC;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [DW-1:0]   pc;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]  ch_valid;
  logic [DW-1:0]   exp_sig;
  logic            core_rst, busy, done, pass, tmo;
  logic [CW-1:0]   cyc;
  logic [DW-1:0]   sig;

  int n_chk;
  int n_fail;

  cpu_run_monitor #(
    .DATA_W       (DW),
    .NUM_CH       (NCH),
    .RST_CYCLES   (RSTC),
    .DRAIN_CYCLES (DRNC),
    .TIMEOUT      (TMO),
    .CNT_W        (CW),
    .HALT_PC      (HALT)
  ) dut (
    .Clk        (clk),
    .Reset      (rst_n),
    .Start      (start),
    .PC         (pc),
    .ChData     (ch_data),
    .ChValid    (ch_valid),
    .ExpSig     (exp_sig),
    .CoreReset  (core_rst),
    .Busy       (busy),
    .Done       (done),
    .Pass       (pass),
    .TimedOut   (tmo),
    .CycleCount (cyc),
    .Signature  (sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]     pcs  [64];
  logic [NCH*DW-1:0] dats [64];
  logic [NCH-1:0]    vals [64];
  logic [DW-1:0]     esig [65];

  function automatic logic [DW-1:0] ref_fold(
    input logic [DW-1:0] s,
    input logic [NCH*DW-1:0] d,
    input logic [NCH-1:0] v
  );
    logic [DW-1:0] r;
    r = s;
    for (int k = 0; k < NCH; k++)
      if (v[k]) r = ((r << 1) | (r >> (DW - 1))) ^ d[k*DW +: DW];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // h < 0 means the program never reaches the halt PC
  task automatic do_run(input int h, input bit match,
                        input bit start_in_drain, input bit directed);
    int total;
    bit timed;
    logic [DW-1:0] expv;
    timed = (h < 0);
    total = timed ? TMO : h + 1 + DRNC;
    for (int j = 0; j < total; j++) begin
      pcs[j] = $urandom;
      if (pcs[j] == HALT) pcs[j] = pcs[j] ^ 32'h4;
      if (j > h && h >= 0 && $urandom_range(0, 2) == 0) pcs[j] = HALT;
      dats[j] = {$urandom, $urandom, $urandom};
      vals[j] = NCH'($urandom_range(0, 7));
    end
    if (h >= 0) pcs[h] = HALT;
    if (directed) begin
      dats[0] = {32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_0001};
      vals[0] = 3'b101;
    end
    esig[0] = '0;
    for (int j = 0; j < total; j++)
      esig[j+1] = ref_fold(esig[j], dats[j], vals[j]);
    expv = match ? esig[total] : esig[total] ^ 32'h0000_5A5A;

    start   = 1'b1;
    exp_sig = expv;
    tick();
    start   = 1'b0;
    exp_sig = $urandom;
    for (int r = 0; r < RSTC; r++) begin
      n_chk++;
      if (core_rst !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_phase r=%0d crst=%b busy=%b done=%b want 1 1 0",
                 r, core_rst, busy, done);
      end
      tick();
    end
    n_chk++;
    if (core_rst !== 1'b0 || busy !== 1'b1 || sig !== '0 || cyc !== '0) begin
      n_fail++;
      $display("FAIL run_entry crst=%b busy=%b sig=%h cnt=%0d want 0 1 0 0",
               core_rst, busy, sig, cyc);
    end
    for (int j = 0; j < total; j++) begin
      pc       = pcs[j];
      ch_data  = dats[j];
      ch_valid = vals[j];
      start    = start_in_drain && (j == h + 2);
      tick();
      start = 1'b0;
      n_chk++;
      if (cyc !== CW'((j + 1 > CMAX) ? CMAX : j + 1) ||
          sig !== esig[j+1] || done !== (j == total - 1)) begin
        n_fail++;
        $display("FAIL run_cycle j=%0d cnt=%0d sig=%h done=%b want %0d %h %b",
                 j, cyc, sig, done, (j + 1 > CMAX) ? CMAX : j + 1,
                 esig[j+1], (j == total - 1));
      end
    end
    n_chk++;
    if (tmo !== timed || pass !== (match && !timed) ||
        busy !== 1'b0 || core_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL verdict tmo=%b pass=%b busy=%b crst=%b want %b %b 0 1",
               tmo, pass, busy, core_rst, timed, match && !timed);
    end
    for (int j = 0; j < 2; j++) begin
      pc       = HALT;
      ch_data  = {$urandom, $urandom, $urandom};
      ch_valid = 3'b111;
      tick();
      n_chk++;
      if (sig !== esig[total] || done !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_hold sig=%h done=%b busy=%b want %h 1 0",
                 sig, done, busy, esig[total]);
      end
    end
    ch_valid = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    n_chk++;
    if (core_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        pass !== 1'b0 || tmo !== 1'b0 || cyc !== '0 || sig !== '0) begin
      n_fail++;
      $display("FAIL reset_state crst=%b busy=%b done=%b pass=%b tmo=%b cnt=%0d sig=%h",
               core_rst, busy, done, pass, tmo, cyc, sig);
    end
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (busy !== 1'b0 || core_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_hold busy=%b crst=%b want 0 1", busy, core_rst);
    end
  endtask

  task automatic test_halt_directed();
    do_run(10, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_mismatch();
    do_run(5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    do_run(-1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_halt_at_timeout();
    do_run(TMO - 1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_halt_first_cycle();
    do_run(0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_run(-1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else
        do_run(int'($urandom_range(0, TMO - 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_reset_mid_run();
    start   = 1'b1;
    exp_sig = $urandom;
    tick();
    start = 1'b0;
    for (int i = 0; i < RSTC + 3; i++) begin
      pc       = $urandom & 32'hFFFF_0000;
      ch_data  = {$urandom, $urandom, $urandom};
      ch_valid = 3'b111;
      tick();
    end
    n_chk++;
    if (busy !== 1'b1 || core_rst !== 1'b0 || cyc !== CW'(3)) begin
      n_fail++;
      $display("FAIL pre_abort busy=%b crst=%b cnt=%0d want 1 0 3",
               busy, core_rst, cyc);
    end
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    n_chk++;
    if (busy !== 1'b0 || core_rst !== 1'b1 || cyc !== '0 ||
        sig !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort busy=%b crst=%b cnt=%0d sig=%h done=%b want 0 1 0 0 0",
               busy, core_rst, cyc, sig, done);
    end
    tick();
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    n_chk++;
    if (busy !== 1'b0 || core_rst !== 1'b1 || cyc !== '0 || sig !== '0) begin
      n_fail++;
      $display("FAIL post_abort busy=%b crst=%b cnt=%0d sig=%h want 0 1 0 0",
               busy, core_rst, cyc, sig);
    end
    ch_valid = '0;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    pc       = '0;
    ch_data  = '0;
    ch_valid = '0;
    exp_sig  = '0;
    tick();
    test_reset();
    test_halt_directed();
    test_mismatch();
    test_timeout();
    test_halt_at_timeout();
    test_halt_first_cycle();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
